// File: rtl/ibex_acc_interconnect.sv
// Crossbar between requesting cores and shared functional units: per-unit round-robin
// request arbitration, core-tagged response routing, per-core credits and local decode errors.
module ibex_acc_interconnect #(
    parameter int unsigned NumCores       = 2,
    parameter int unsigned NumAcc         = 2,
    parameter int unsigned AddrWidth      = 32,
    parameter int unsigned IdWidth        = 5,
    parameter int unsigned DataWidth      = 32,
    parameter int unsigned MaxOutstanding = 4,
    localparam int unsigned CW  = (NumCores > 1) ? $clog2(NumCores) : 1,
    localparam int unsigned TW  = IdWidth + CW,
    localparam int unsigned AW  = (NumAcc > 1) ? $clog2(NumAcc) : 1,
    localparam int unsigned CRW = $clog2(MaxOutstanding + 1),
    localparam int unsigned ARW = 3 * DataWidth
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic [NumCores-1:0]           core_req_valid_i,
    output logic [NumCores-1:0]           core_req_ready_o,
    input  logic [NumCores*AddrWidth-1:0] core_req_addr_i,
    input  logic [NumCores*IdWidth-1:0]   core_req_id_i,
    input  logic [NumCores*32-1:0]        core_req_instr_i,
    input  logic [NumCores*ARW-1:0]       core_req_args_i,
    output logic [NumCores-1:0]           core_resp_valid_o,
    input  logic [NumCores-1:0]           core_resp_ready_i,
    output logic [NumCores*IdWidth-1:0]   core_resp_id_o,
    output logic [NumCores-1:0]           core_resp_error_o,
    output logic [NumCores*DataWidth-1:0] core_resp_data_o,
    output logic [NumAcc-1:0]             acc_req_valid_o,
    input  logic [NumAcc-1:0]             acc_req_ready_i,
    output logic [NumAcc*TW-1:0]          acc_req_id_o,
    output logic [NumAcc*32-1:0]          acc_req_instr_o,
    output logic [NumAcc*ARW-1:0]         acc_req_args_o,
    input  logic [NumAcc-1:0]             acc_resp_valid_i,
    output logic [NumAcc-1:0]             acc_resp_ready_o,
    input  logic [NumAcc*TW-1:0]          acc_resp_id_i,
    input  logic [NumAcc-1:0]             acc_resp_error_i,
    input  logic [NumAcc*DataWidth-1:0]   acc_resp_data_i
);

    logic [CW-1:0]        req_ptr  [NumAcc];
    logic [CW-1:0]        hold_idx [NumAcc];
    logic [NumAcc-1:0]    hold_vld;
    logic [AW-1:0]        resp_ptr [NumCores];
    logic [CRW-1:0]       credit   [NumCores];
    logic [NumCores-1:0]  err_vld;
    logic [IdWidth-1:0]   err_id   [NumCores];

    logic [NumCores-1:0]  eligible, bad, req_ready;
    logic [NumCores-1:0]  cand     [NumAcc];
    logic [NumAcc-1:0]    req_valid;
    logic [CW-1:0]        grant    [NumAcc];
    logic [NumAcc*TW-1:0]    acc_id;
    logic [NumAcc*32-1:0]    acc_instr;
    logic [NumAcc*ARW-1:0]   acc_args;

    logic [NumCores-1:0]  resp_valid, from_err, resp_hs;
    logic [AW-1:0]        resp_sel [NumCores];
    logic [CW-1:0]        rcore    [NumAcc];
    logic [NumAcc-1:0]    resp_ready;
    logic [NumCores*IdWidth-1:0]   resp_id;
    logic [NumCores-1:0]           resp_err;
    logic [NumCores*DataWidth-1:0] resp_data;

    always_comb begin
        for (int c = 0; c < NumCores; c++) begin
            eligible[c] = core_req_valid_i[c] && (credit[c] < CRW'(MaxOutstanding));
            bad[c]      = core_req_addr_i[c*AddrWidth +: AddrWidth] >= AddrWidth'(NumAcc);
        end
        for (int a = 0; a < NumAcc; a++) begin
            for (int c = 0; c < NumCores; c++) begin
                cand[a][c] = eligible[c] &&
                             (core_req_addr_i[c*AddrWidth +: AddrWidth] == AddrWidth'(a));
            end
        end
    end

    // A grant stalled by the unit stays with the same core while that core keeps asking.
    always_comb begin
        int idx;
        int g;
        idx       = 0;
        g         = 0;
        req_valid = '0;
        req_ready = '0;
        acc_id    = '0;
        acc_instr = '0;
        acc_args  = '0;
        for (int a = 0; a < NumAcc; a++) begin
            grant[a] = '0;
            if (hold_vld[a] && cand[a][hold_idx[a]]) begin
                req_valid[a] = 1'b1;
                grant[a]     = hold_idx[a];
            end else begin
                for (int k = 0; k < NumCores; k++) begin
                    idx = int'(req_ptr[a]) + k;
                    if (idx >= int'(NumCores)) idx = idx - int'(NumCores);
                    if (!req_valid[a] && cand[a][idx]) begin
                        req_valid[a] = 1'b1;
                        grant[a]     = CW'(idx);
                    end
                end
            end
            g = int'(grant[a]);
            acc_id[a*TW +: TW]      = {grant[a], core_req_id_i[g*IdWidth +: IdWidth]};
            acc_instr[a*32 +: 32]   = core_req_instr_i[g*32 +: 32];
            acc_args[a*ARW +: ARW]  = core_req_args_i[g*ARW +: ARW];
        end
        for (int c = 0; c < NumCores; c++) begin
            req_ready[c] = bad[c] && eligible[c] && !err_vld[c];
        end
        for (int a = 0; a < NumAcc; a++) begin
            if (req_valid[a] && acc_req_ready_i[a]) req_ready[grant[a]] = 1'b1;
        end
    end

    // Pending decode errors beat unit responses; units share a per-core round-robin.
    always_comb begin
        int idx;
        int rc;
        int s;
        idx        = 0;
        rc         = 0;
        s          = 0;
        resp_valid = '0;
        from_err   = '0;
        resp_ready = '0;
        resp_id    = '0;
        resp_err   = '0;
        resp_data  = '0;
        for (int a = 0; a < NumAcc; a++) rcore[a] = acc_resp_id_i[a*TW + IdWidth +: CW];
        for (int c = 0; c < NumCores; c++) begin
            resp_sel[c] = '0;
            if (err_vld[c]) begin
                resp_valid[c] = 1'b1;
                from_err[c]   = 1'b1;
            end else begin
                for (int k = 0; k < NumAcc; k++) begin
                    idx = int'(resp_ptr[c]) + k;
                    if (idx >= int'(NumAcc)) idx = idx - int'(NumAcc);
                    if (!resp_valid[c] && acc_resp_valid_i[idx] && int'(rcore[idx]) == c) begin
                        resp_valid[c] = 1'b1;
                        resp_sel[c]   = AW'(idx);
                    end
                end
            end
            s = int'(resp_sel[c]);
            if (from_err[c]) begin
                resp_id[c*IdWidth +: IdWidth] = err_id[c];
                resp_err[c]                   = 1'b1;
            end else if (resp_valid[c]) begin
                resp_id[c*IdWidth +: IdWidth]     = acc_resp_id_i[s*TW +: IdWidth];
                resp_err[c]                       = acc_resp_error_i[s];
                resp_data[c*DataWidth +: DataWidth] = acc_resp_data_i[s*DataWidth +: DataWidth];
            end
        end
        for (int a = 0; a < NumAcc; a++) begin
            rc = int'(rcore[a]);
            if (rc >= int'(NumCores)) begin
                resp_ready[a] = 1'b1;
            end else begin
                resp_ready[a] = resp_valid[rc] && !from_err[rc] &&
                                (resp_sel[rc] == AW'(a)) && core_resp_ready_i[rc];
            end
        end
    end

    assign resp_hs = resp_valid & core_resp_ready_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hold_vld <= '0;
            err_vld  <= '0;
            for (int a = 0; a < NumAcc; a++) begin
                req_ptr[a]  <= '0;
                hold_idx[a] <= '0;
            end
            for (int c = 0; c < NumCores; c++) begin
                resp_ptr[c] <= '0;
                credit[c]   <= '0;
                err_id[c]   <= '0;
            end
        end else begin
            for (int a = 0; a < NumAcc; a++) begin
                if (req_valid[a] && acc_req_ready_i[a]) begin
                    req_ptr[a]  <= CW'((int'(grant[a]) + 1) % int'(NumCores));
                    hold_vld[a] <= 1'b0;
                end else begin
                    hold_vld[a] <= req_valid[a];
                    hold_idx[a] <= grant[a];
                end
            end
            for (int c = 0; c < NumCores; c++) begin
                if (req_ready[c] && bad[c]) begin
                    err_vld[c] <= 1'b1;
                    err_id[c]  <= core_req_id_i[c*IdWidth +: IdWidth];
                end else if (resp_hs[c] && from_err[c]) begin
                    err_vld[c] <= 1'b0;
                end
                if (req_ready[c] && !resp_hs[c]) begin
                    credit[c] <= credit[c] + 1'b1;
                end else if (!req_ready[c] && resp_hs[c] && credit[c] != '0) begin
                    credit[c] <= credit[c] - 1'b1;
                end
                if (resp_hs[c] && !from_err[c]) begin
                    resp_ptr[c] <= AW'((int'(resp_sel[c]) + 1) % int'(NumAcc));
                end
            end
        end
    end

    // Everything facing the outside is forced quiet while reset is held.
    assign core_req_ready_o  = rst_ni ? req_ready  : '0;
    assign core_resp_valid_o = rst_ni ? resp_valid : '0;
    assign core_resp_id_o    = rst_ni ? resp_id    : '0;
    assign core_resp_error_o = rst_ni ? resp_err   : '0;
    assign core_resp_data_o  = rst_ni ? resp_data  : '0;
    assign acc_req_valid_o   = rst_ni ? req_valid  : '0;
    assign acc_req_id_o      = rst_ni ? acc_id     : '0;
    assign acc_req_instr_o   = rst_ni ? acc_instr  : '0;
    assign acc_req_args_o    = rst_ni ? acc_args   : '0;
    assign acc_resp_ready_o  = rst_ni ? resp_ready : '0;

endmodule

// File: tb/tb_ibex_acc_interconnect.sv
// Directed scenarios followed by random traffic, all checked against a
// transaction-level reference model of arbitration, credits and error slots.
module tb_ibex_acc_interconnect;
    localparam int NC = 2, NA = 2, AWD = 32, IW = 5, DW = 32, MO = 4;
    localparam int TW = IW + 1;

    logic              clk = 1'b0;
    logic              rst_ni = 1'b0;
    logic [NC-1:0]     core_req_valid, core_req_ready, core_resp_valid, core_resp_ready, core_resp_error;
    logic [NC*AWD-1:0] core_req_addr;
    logic [NC*IW-1:0]  core_req_id, core_resp_id;
    logic [NC*32-1:0]  core_req_instr;
    logic [NC*96-1:0]  core_req_args;
    logic [NC*DW-1:0]  core_resp_data;
    logic [NA-1:0]     acc_req_valid, acc_req_ready, acc_resp_valid, acc_resp_ready, acc_resp_error;
    logic [NA*TW-1:0]  acc_req_id, acc_resp_id;
    logic [NA*32-1:0]  acc_req_instr;
    logic [NA*96-1:0]  acc_req_args;
    logic [NA*DW-1:0]  acc_resp_data;

    ibex_acc_interconnect #(
        .NumCores(NC), .NumAcc(NA), .AddrWidth(AWD), .IdWidth(IW),
        .DataWidth(DW), .MaxOutstanding(MO)
    ) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .core_req_valid_i(core_req_valid), .core_req_ready_o(core_req_ready),
        .core_req_addr_i(core_req_addr), .core_req_id_i(core_req_id),
        .core_req_instr_i(core_req_instr), .core_req_args_i(core_req_args),
        .core_resp_valid_o(core_resp_valid), .core_resp_ready_i(core_resp_ready),
        .core_resp_id_o(core_resp_id), .core_resp_error_o(core_resp_error),
        .core_resp_data_o(core_resp_data),
        .acc_req_valid_o(acc_req_valid), .acc_req_ready_i(acc_req_ready),
        .acc_req_id_o(acc_req_id), .acc_req_instr_o(acc_req_instr),
        .acc_req_args_o(acc_req_args),
        .acc_resp_valid_i(acc_resp_valid), .acc_resp_ready_o(acc_resp_ready),
        .acc_resp_id_i(acc_resp_id), .acc_resp_error_i(acc_resp_error),
        .acc_resp_data_i(acc_resp_data)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    int m_ptr[NA];
    bit m_lk_v[NA];
    int m_lk[NA];
    int m_cred[NC];
    bit m_err[NC];
    logic [IW-1:0] m_errid[NC];
    int m_rptr[NC];
    // Model predictions for the current cycle
    bit e_av[NA];
    int e_g[NA];
    bit e_crdy[NC];
    bit e_rv[NC];
    bit e_src_err[NC];
    int e_src[NC];
    bit e_arrdy[NA];

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        for (int a = 0; a < NA; a++) begin m_ptr[a] = 0; m_lk_v[a] = 0; m_lk[a] = 0; end
        for (int c = 0; c < NC; c++) begin m_cred[c] = 0; m_err[c] = 0; m_errid[c] = '0; m_rptr[c] = 0; end
    endfunction

    function automatic int unsigned addr_of(int c);
        return core_req_addr[c*AWD +: AWD];
    endfunction

    function automatic bit m_cand(int c, int unsigned a);
        return core_req_valid[c] && (m_cred[c] < MO) && (addr_of(c) == a);
    endfunction

    function automatic int tag_core(int a);
        return int'(acc_resp_id[a*TW + IW]);
    endfunction

    function automatic void model_eval();
        int best, bd, d, tc;
        for (int a = 0; a < NA; a++) begin
            best = -1;
            bd = NC;
            if (m_lk_v[a] && m_cand(m_lk[a], a)) begin
                best = m_lk[a];
            end else begin
                for (int c = 0; c < NC; c++) begin
                    d = (c - m_ptr[a] + NC) % NC;
                    if (m_cand(c, a) && d < bd) begin best = c; bd = d; end
                end
            end
            e_av[a] = (best >= 0);
            e_g[a]  = (best >= 0) ? best : 0;
        end
        for (int c = 0; c < NC; c++) begin
            if (addr_of(c) >= NA) begin
                e_crdy[c] = core_req_valid[c] && (m_cred[c] < MO) && !m_err[c];
            end else begin
                e_crdy[c] = 0;
                for (int a = 0; a < NA; a++)
                    if (e_av[a] && e_g[a] == c && acc_req_ready[a]) e_crdy[c] = 1;
            end
            e_src_err[c] = m_err[c];
            e_src[c] = -1;
            if (!m_err[c]) begin
                bd = NA;
                for (int a = 0; a < NA; a++) begin
                    d = (a - m_rptr[c] + NA) % NA;
                    if (acc_resp_valid[a] && tag_core(a) == c && d < bd) begin e_src[c] = a; bd = d; end
                end
            end
            e_rv[c] = m_err[c] || (e_src[c] >= 0);
        end
        for (int a = 0; a < NA; a++) begin
            tc = tag_core(a);
            if (tc >= NC) e_arrdy[a] = 1;
            else e_arrdy[a] = !e_src_err[tc] && (e_src[tc] == a) && core_resp_ready[tc];
        end
    endfunction

    function automatic void model_update();
        bit hq, hr;
        for (int a = 0; a < NA; a++) begin
            if (e_av[a] && acc_req_ready[a]) begin
                m_ptr[a] = (e_g[a] + 1) % NC;
                m_lk_v[a] = 0;
            end else begin
                m_lk_v[a] = e_av[a];
                m_lk[a] = e_g[a];
            end
        end
        for (int c = 0; c < NC; c++) begin
            hq = e_crdy[c] && core_req_valid[c];
            hr = e_rv[c] && core_resp_ready[c];
            if (hq && addr_of(c) >= NA) begin
                m_err[c] = 1;
                m_errid[c] = core_req_id[c*IW +: IW];
            end else if (hr && e_src_err[c]) begin
                m_err[c] = 0;
            end
            if (hq && !hr) m_cred[c]++;
            else if (!hq && hr && m_cred[c] > 0) m_cred[c]--;
            if (hr && !e_src_err[c]) m_rptr[c] = (e_src[c] + 1) % NA;
        end
    endfunction

    task automatic compare_all();
        logic [TW-1:0] t;
        int s;
        for (int a = 0; a < NA; a++) begin
            check($sformatf("acc_req_valid[%0d]", a), 128'(acc_req_valid[a]), 128'(e_av[a]));
            if (e_av[a]) begin
                t = {1'(e_g[a]), core_req_id[e_g[a]*IW +: IW]};
                check($sformatf("acc_req_id[%0d]", a), 128'(acc_req_id[a*TW +: TW]), 128'(t));
                check($sformatf("acc_req_instr[%0d]", a), 128'(acc_req_instr[a*32 +: 32]),
                      128'(core_req_instr[e_g[a]*32 +: 32]));
                check($sformatf("acc_req_args[%0d]", a), 128'(acc_req_args[a*96 +: 96]),
                      128'(core_req_args[e_g[a]*96 +: 96]));
            end
            if (acc_resp_valid[a])
                check($sformatf("acc_resp_ready[%0d]", a), 128'(acc_resp_ready[a]), 128'(e_arrdy[a]));
        end
        for (int c = 0; c < NC; c++) begin
            check($sformatf("core_req_ready[%0d]", c), 128'(core_req_ready[c]), 128'(e_crdy[c]));
            check($sformatf("core_resp_valid[%0d]", c), 128'(core_resp_valid[c]), 128'(e_rv[c]));
            if (e_rv[c]) begin
                s = e_src[c];
                check($sformatf("core_resp_id[%0d]", c), 128'(core_resp_id[c*IW +: IW]),
                      e_src_err[c] ? 128'(m_errid[c]) : 128'(acc_resp_id[s*TW +: IW]));
                check($sformatf("core_resp_error[%0d]", c), 128'(core_resp_error[c]),
                      e_src_err[c] ? 128'(1) : 128'(acc_resp_error[s]));
                check($sformatf("core_resp_data[%0d]", c), 128'(core_resp_data[c*DW +: DW]),
                      e_src_err[c] ? 128'(0) : 128'(acc_resp_data[s*DW +: DW]));
            end
        end
    endtask

    task automatic settle();
        @(negedge clk);
        model_eval();
        compare_all();
    endtask

    task automatic advance();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic clear_inputs();
        core_req_valid = '0; core_req_addr = '0; core_req_id = '0;
        core_req_instr = '0; core_req_args = '0; core_resp_ready = '0;
        acc_req_ready = '0; acc_resp_valid = '0; acc_resp_id = '0;
        acc_resp_error = '0; acc_resp_data = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_ni = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        rst_ni = 1'b1;
    endtask

    task automatic set_req(input int c, input bit v, input int unsigned ad, input logic [IW-1:0] id,
                           input logic [31:0] instr, input logic [95:0] args);
        core_req_valid[c] = v;
        core_req_addr[c*AWD +: AWD] = ad;
        core_req_id[c*IW +: IW] = id;
        core_req_instr[c*32 +: 32] = instr;
        core_req_args[c*96 +: 96] = args;
    endtask

    task automatic set_rsp(input int a, input bit v, input logic [TW-1:0] tag,
                           input bit err, input logic [DW-1:0] data);
        acc_resp_valid[a] = v;
        acc_resp_id[a*TW +: TW] = tag;
        acc_resp_error[a] = err;
        acc_resp_data[a*DW +: DW] = data;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_acc_req_valid"}, 128'(acc_req_valid), 128'(0));
        check({tag, "_core_req_ready"}, 128'(core_req_ready), 128'(0));
        check({tag, "_core_resp_valid"}, 128'(core_resp_valid), 128'(0));
        check({tag, "_acc_resp_ready"}, 128'(acc_resp_ready), 128'(0));
        check({tag, "_acc_req_args"}, 128'(acc_req_args), 128'(0));
        check({tag, "_core_resp_data"}, 128'(core_resp_data), 128'(0));
    endtask

    initial begin
        clear_inputs();
        model_reset();
        // Busy inputs while reset is held: every output must stay quiet.
        set_req(0, 1, 0, 5'd1, 32'h1, 96'h1);
        set_req(1, 1, 1, 5'd2, 32'h2, 96'h2);
        acc_req_ready = '1; core_resp_ready = '1;
        set_rsp(0, 1, 6'd1, 0, 32'hAA);
        #3;
        check_quiet("in_reset");
        do_reset();

        // Single offload round trip through unit 1.
        set_req(0, 1, 1, 5'd7, 32'hDEAD0001, 96'd3);
        acc_req_ready = 2'b10;
        settle();
        check("s1_acc_valid", 128'(acc_req_valid), 128'(2'b10));
        check("s1_tag", 128'(acc_req_id[TW +: TW]), 128'(6'd7));
        check("s1_args", 128'(acc_req_args[96 +: 96]), 128'(96'd3));
        check("s1_core_ready", 128'(core_req_ready[0]), 128'(1));
        advance();
        set_req(0, 0, 1, 5'd7, 32'hDEAD0001, 96'd3);
        set_rsp(1, 1, 6'd7, 0, 32'h15);
        core_resp_ready = 2'b01;
        settle();
        check("s1_resp_valid", 128'(core_resp_valid[0]), 128'(1));
        check("s1_resp_id", 128'(core_resp_id[0 +: IW]), 128'(5'd7));
        check("s1_resp_data", 128'(core_resp_data[0 +: DW]), 128'(32'h15));
        check("s1_resp_err", 128'(core_resp_error[0]), 128'(0));
        check("s1_acc_resp_ready", 128'(acc_resp_ready[1]), 128'(1));
        advance();

        // Two cores contending for unit 0: alternation, then a stalled grant holds.
        do_reset();
        set_req(0, 1, 0, 5'd10, 32'hA0, 96'hA);
        set_req(1, 1, 0, 5'd11, 32'hB0, 96'hB);
        acc_req_ready = 2'b01;
        for (int i = 0; i < 4; i++) begin
            settle();
            check($sformatf("s2_rr%0d", i), 128'(core_req_ready), (i % 2 == 0) ? 128'(2'b01) : 128'(2'b10));
            advance();
        end
        acc_req_ready = 2'b00;
        for (int i = 0; i < 3; i++) begin
            settle();
            check($sformatf("s2_hold_core%0d", i), 128'(acc_req_id[IW]), 128'(0));
            check($sformatf("s2_hold_valid%0d", i), 128'(acc_req_valid[0]), 128'(1));
            advance();
        end

        // Decode error path with a second bad request stalled behind the first.
        do_reset();
        set_req(1, 1, 5, 5'd3, 32'h0, 96'h0);
        settle();
        check("s3_bad_ready", 128'(core_req_ready[1]), 128'(1));
        check("s3_no_acc", 128'(acc_req_valid), 128'(0));
        advance();
        set_req(1, 1, 5, 5'd4, 32'h0, 96'h0);
        for (int i = 0; i < 2; i++) begin
            settle();
            check("s3_err_valid", 128'(core_resp_valid[1]), 128'(1));
            check("s3_err_id", 128'(core_resp_id[IW +: IW]), 128'(5'd3));
            check("s3_err_flag", 128'(core_resp_error[1]), 128'(1));
            check("s3_err_data", 128'(core_resp_data[DW +: DW]), 128'(0));
            check("s3_second_stalled", 128'(core_req_ready[1]), 128'(0));
            advance();
        end
        core_resp_ready = 2'b10;
        settle();
        advance();
        settle();
        check("s3_second_accepted", 128'(core_req_ready[1]), 128'(1));
        advance();
        set_req(1, 0, 5, 5'd4, 32'h0, 96'h0);
        core_resp_ready = 2'b00;
        settle();
        check("s3_second_id", 128'(core_resp_id[IW +: IW]), 128'(5'd4));
        advance();

        // Credit limit, with one simultaneous issue-and-retire along the way.
        do_reset();
        set_req(0, 1, 0, 5'd9, 32'h9, 96'h9);
        acc_req_ready = 2'b01;
        core_resp_ready = 2'b01;
        for (int i = 0; i < 3; i++) begin settle(); advance(); end
        set_rsp(0, 1, 6'd9, 0, 32'h99);
        settle();
        check("s4_sim_req", 128'(core_req_ready[0]), 128'(1));
        check("s4_sim_rsp", 128'(acc_resp_ready[0]), 128'(1));
        advance();
        set_rsp(0, 0, 6'd0, 0, 32'h0);
        settle();
        check("s4_fourth", 128'(core_req_ready[0]), 128'(1));
        advance();
        for (int i = 0; i < 2; i++) begin
            settle();
            check("s4_blocked", 128'(core_req_ready[0]), 128'(0));
            advance();
        end

        // Simultaneous unit responses to one core, held while the core stalls.
        do_reset();
        set_rsp(0, 1, 6'd1, 0, 32'h111);
        set_rsp(1, 1, 6'd2, 1, 32'h222);
        for (int i = 0; i < 2; i++) begin
            settle();
            check("s5_hold_valid", 128'(core_resp_valid[0]), 128'(1));
            check("s5_hold_data", 128'(core_resp_data[0 +: DW]), 128'(32'h111));
            advance();
        end
        core_resp_ready = 2'b01;
        settle();
        check("s5_first_ready", 128'(acc_resp_ready), 128'(2'b01));
        advance();
        set_rsp(0, 0, 6'd0, 0, 32'h0);
        settle();
        check("s5_second_id", 128'(core_resp_id[0 +: IW]), 128'(5'd2));
        check("s5_second_ready", 128'(acc_resp_ready), 128'(2'b10));
        advance();

        // Reset asserted in the middle of traffic.
        do_reset();
        set_req(0, 1, 1, 5'd6, 32'h6, 96'h6);
        acc_req_ready = 2'b10;
        for (int i = 0; i < 2; i++) begin settle(); advance(); end
        set_rsp(1, 1, 6'd6, 0, 32'h66);
        core_resp_ready = 2'b01;
        #2;
        rst_ni = 1'b0;
        #1;
        check_quiet("mid_reset");
        model_reset();
        @(posedge clk);
        #1;
        rst_ni = 1'b1;
        set_rsp(1, 0, 6'd0, 0, 32'h0);
        settle();
        check("s6_after_reset_ready", 128'(core_req_ready[0]), 128'(1));
        advance();

        // Random traffic against the reference model.
        do_reset();
        for (int n = 0; n < 400; n++) begin
            for (int c = 0; c < NC; c++) begin
                set_req(c, 1'($urandom_range(0, 9) < 7), $urandom_range(0, 3), IW'($urandom),
                        $urandom, {$urandom, $urandom, $urandom});
                core_resp_ready[c] = 1'($urandom_range(0, 1));
            end
            for (int a = 0; a < NA; a++) begin
                acc_req_ready[a] = 1'($urandom_range(0, 1));
                set_rsp(a, 1'($urandom_range(0, 9) < 4), TW'($urandom), 1'($urandom), $urandom);
            end
            settle();
            advance();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
